pzvbus_arbiter_mux: RTL and testbench

Multi-slave pzvbus arbiter/multiplexer: merges SLAVES upstream pzvbus channels onto one downstream channel. Arbitration is fixed-priority or round-robin, with per-slave request enables, a grant lock of up to MAX_BURST beats, and an optional registered output slice. It generalises the one-hot priority mux: it replaces hand-built select logic wherever several pzvbus producers share one consumer.

---
 rtl/pzvbus_arbiter_pkg.sv | 11 +
 rtl/pzvbus_if.sv | 11 +
 rtl/pzvbus_arbiter_core.sv | 94 +++++++++
 rtl/pzvbus_slicer.sv | 49 ++++
 rtl/pzvbus_arbiter_mux.sv | 72 +++++++
 tb/tb_pzvbus_arbiter_mux.sv | 240 ++++++++++++++++++++++++
 6 files changed

// File: rtl/pzvbus_arbiter_pkg.sv
// Shared types and constants for the pzvbus arbiter/multiplexer slice.
package pzvbus_arbiter_pkg;

   typedef enum logic {
      PZVBUS_ARB_FIXED,
      PZVBUS_ARB_ROUND_ROBIN
   } pzvbus_arbiter_type;

   localparam int PZVBUS_DATA_W = 16;

endpackage

// File: rtl/pzvbus_if.sv
// pzvbus valid/ready channel; "master" drives a beat, "slave" accepts it.
interface pzvbus_if;

   logic                                       valid;
   logic                                       ready;
   logic [pzvbus_arbiter_pkg::PZVBUS_DATA_W-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pzvbus_arbiter_core.sv
// Grant generation: fixed or round-robin arbitration, burst lock and RR pointer.
module pzvbus_arbiter_core
   import pzvbus_arbiter_pkg::*;
#(
   parameter int                 SLAVES       = 2,
   parameter pzvbus_arbiter_type ARBITER_TYPE = PZVBUS_ARB_FIXED,
   parameter int                 MAX_BURST    = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [SLAVES-1:0] i_valid,
   input  logic [SLAVES-1:0] i_enable,
   input  logic              i_ready,
   output logic [SLAVES-1:0] o_grant,
   output logic              o_in_valid,
   output logic              o_locked
);

   localparam int PTR_W = $clog2(SLAVES);
   localparam int CNT_W = $clog2(MAX_BURST) + 1;

   logic              r_locked;
   logic              r_stalled;
   logic [SLAVES-1:0] r_lock_grant;
   logic [CNT_W-1:0]  r_beat_cnt;
   logic [PTR_W-1:0]  r_rr_ptr;

   logic [SLAVES-1:0] w_req;
   logic [SLAVES-1:0] w_masked;
   logic [SLAVES-1:0] w_fixed;
   logic [SLAVES-1:0] w_rr;
   logic [SLAVES-1:0] w_grant;
   logic [PTR_W-1:0]  w_winner;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic              w_in_valid;
   logic              w_accept;

   // A stalled beat keeps its request even if its enable drops; reset blanks all grants.
   assign w_req = i_valid & (i_enable | ((r_locked & r_stalled) ? r_lock_grant : '0))
                  & {SLAVES{i_rst_n}};

   // NOTE: every variable in a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      w_masked = '0;
      w_winner = '0;
      for (int i = 0; i < SLAVES; i++) begin
         w_masked[i] = w_req[i] & (i >= int'(r_rr_ptr));
         if (w_grant[i]) w_winner = PTR_W'(i);
      end
   end

   assign w_fixed    = w_req & (-w_req);
   assign w_rr       = (|w_masked) ? (w_masked & (-w_masked)) : w_fixed;
   assign w_grant    = r_locked ? r_lock_grant
                     : ((ARBITER_TYPE == PZVBUS_ARB_ROUND_ROBIN) ? w_rr : w_fixed);
   assign w_in_valid = |(w_grant & w_req);
   assign w_accept   = w_in_valid & i_ready;
   assign w_cnt_inc  = r_beat_cnt + CNT_W'(1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_locked     <= 1'b0;
         r_stalled    <= 1'b0;
         r_lock_grant <= '0;
         r_beat_cnt   <= '0;
         r_rr_ptr     <= '0;
      end else begin
         r_stalled <= w_in_valid & ~i_ready;
         if (!r_locked) begin
            if (w_accept)
               r_rr_ptr <= (w_winner == PTR_W'(SLAVES - 1)) ? '0 : w_winner + PTR_W'(1);
            if (w_accept && MAX_BURST > 1) begin
               r_locked     <= 1'b1;
               r_lock_grant <= w_grant;
               r_beat_cnt   <= CNT_W'(1);
            end else if (w_in_valid && !i_ready) begin
               r_locked     <= 1'b1;
               r_lock_grant <= w_grant;
               r_beat_cnt   <= '0;
            end
         end else if (w_accept) begin
            r_beat_cnt <= w_cnt_inc;
            if (w_cnt_inc == CNT_W'(MAX_BURST)) r_locked <= 1'b0;
         end else if (!w_in_valid) begin
            r_locked <= 1'b0;
         end
      end
   end

   assign o_grant    = w_grant;
   assign o_in_valid = w_in_valid;
   assign o_locked   = r_locked;

endmodule

// File: rtl/pzvbus_slicer.sv
// Two-entry full-throughput register slice: ready = not full, valid = not empty.
module pzvbus_slicer #(
   parameter int DATA_W = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   input  logic              i_ready
);

   logic [DATA_W-1:0] r_mem [2];
   logic              r_wr_ptr;
   logic              r_rd_ptr;
   logic [1:0]        r_count;
   logic              w_push;
   logic              w_pop;

   assign o_ready = (r_count != 2'd2);
   assign o_valid = (r_count != 2'd0);
   assign o_data  = r_mem[r_rd_ptr];
   assign w_push  = i_valid & o_ready;
   assign w_pop   = o_valid & i_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage is not reset; r_count alone decides which entries are valid.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/pzvbus_arbiter_mux.sv
// Merges SLAVES upstream pzvbus channels onto one downstream channel.
module pzvbus_arbiter_mux
   import pzvbus_arbiter_pkg::*;
#(
   parameter int                 SLAVES       = 2,
   parameter pzvbus_arbiter_type ARBITER_TYPE = PZVBUS_ARB_FIXED,
   parameter int                 MAX_BURST    = 1,
   parameter bit                 OUTPUT_SLICE = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [SLAVES-1:0] i_enable,
   pzvbus_if.slave           slave_if [SLAVES],
   pzvbus_if.master          master_if,
   output logic [SLAVES-1:0] o_grant,
   output logic              o_locked
);

   logic [SLAVES-1:0]        w_valid;
   logic [PZVBUS_DATA_W-1:0] w_data [SLAVES];
   logic [PZVBUS_DATA_W-1:0] w_mux_data;
   logic [SLAVES-1:0]        w_grant;
   logic                     w_in_valid;
   logic                     w_in_ready;

   for (genvar g = 0; g < SLAVES; g++) begin : g_slave
      assign w_valid[g]        = slave_if[g].valid;
      assign w_data[g]         = slave_if[g].data;
      assign slave_if[g].ready = w_grant[g] & w_in_ready;
   end

   always_comb begin
      w_mux_data = '0;
      for (int i = 0; i < SLAVES; i++)
         if (w_grant[i]) w_mux_data = w_mux_data | w_data[i];
   end

   pzvbus_arbiter_core #(
      .SLAVES       (SLAVES),
      .ARBITER_TYPE (ARBITER_TYPE),
      .MAX_BURST    (MAX_BURST)
   ) u_core (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_valid    (w_valid),
      .i_enable   (i_enable),
      .i_ready    (w_in_ready),
      .o_grant    (w_grant),
      .o_in_valid (w_in_valid),
      .o_locked   (o_locked)
   );

   if (OUTPUT_SLICE) begin : g_slice
      pzvbus_slicer #(.DATA_W(PZVBUS_DATA_W)) u_slicer (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_valid (w_in_valid),
         .i_data  (w_mux_data),
         .o_ready (w_in_ready),
         .o_valid (master_if.valid),
         .o_data  (master_if.data),
         .i_ready (master_if.ready)
      );
   end else begin : g_bypass
      assign master_if.valid = w_in_valid;
      assign master_if.data  = w_mux_data;
      assign w_in_ready      = master_if.ready;
   end

   assign o_grant = w_grant;

endmodule

// File: tb/tb_pzvbus_arbiter_mux.sv
// Directed bench: four arbiter configurations driven with hand-computed vectors.
module tb_pzvbus_arbiter_mux;
   import pzvbus_arbiter_pkg::*;

   logic i_clk = 1'b0;
   logic i_rst_n;
   always #5 i_clk = ~i_clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #2;
   endtask

   // a: FIXED, 4 slaves, MAX_BURST=1, slice
   logic [3:0] a_valid, a_en, a_rdy, a_grant;
   logic a_mready, a_mvalid, a_locked;
   logic [15:0] a_mdata;
   pzvbus_if a_s[4] ();
   pzvbus_if a_m ();
   // b: ROUND_ROBIN, 4 slaves, MAX_BURST=1, slice
   logic [3:0] b_valid, b_en, b_grant;
   logic b_mready, b_mvalid, b_locked;
   logic [15:0] b_mdata;
   pzvbus_if b_s[4] ();
   pzvbus_if b_m ();
   // c: ROUND_ROBIN, 4 slaves, MAX_BURST=4, slice
   logic [3:0] c_valid, c_en, c_rdy, c_grant;
   logic c_mready, c_mvalid, c_locked;
   logic [15:0] c_mdata;
   pzvbus_if c_s[4] ();
   pzvbus_if c_m ();
   // d: FIXED, 2 slaves, MAX_BURST=1, no slice
   logic [1:0] d_valid, d_en, d_rdy, d_grant;
   logic d_mready, d_mvalid, d_locked;
   logic [15:0] d_mdata;
   pzvbus_if d_s[2] ();
   pzvbus_if d_m ();

   for (genvar g = 0; g < 4; g++) begin : g_abc
      assign a_s[g].valid = a_valid[g];
      assign a_s[g].data  = 16'hC0 + 16'(g);
      assign a_rdy[g]     = a_s[g].ready;
      assign b_s[g].valid = b_valid[g];
      assign b_s[g].data  = 16'hC0 + 16'(g);
      assign c_s[g].valid = c_valid[g];
      assign c_s[g].data  = 16'hC0 + 16'(g);
      assign c_rdy[g]     = c_s[g].ready;
   end
   for (genvar g = 0; g < 2; g++) begin : g_d
      assign d_s[g].valid = d_valid[g];
      assign d_s[g].data  = 16'hC0 + 16'(g);
      assign d_rdy[g]     = d_s[g].ready;
   end

   assign a_m.ready = a_mready;  assign a_mvalid = a_m.valid;  assign a_mdata = a_m.data;
   assign b_m.ready = b_mready;  assign b_mvalid = b_m.valid;  assign b_mdata = b_m.data;
   assign c_m.ready = c_mready;  assign c_mvalid = c_m.valid;  assign c_mdata = c_m.data;
   assign d_m.ready = d_mready;  assign d_mvalid = d_m.valid;  assign d_mdata = d_m.data;

   pzvbus_arbiter_mux #(.SLAVES(4), .ARBITER_TYPE(PZVBUS_ARB_FIXED), .MAX_BURST(1),
                        .OUTPUT_SLICE(1'b1)) u_a (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(a_en), .slave_if(a_s),
      .master_if(a_m), .o_grant(a_grant), .o_locked(a_locked));
   pzvbus_arbiter_mux #(.SLAVES(4), .ARBITER_TYPE(PZVBUS_ARB_ROUND_ROBIN), .MAX_BURST(1),
                        .OUTPUT_SLICE(1'b1)) u_b (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(b_en), .slave_if(b_s),
      .master_if(b_m), .o_grant(b_grant), .o_locked(b_locked));
   pzvbus_arbiter_mux #(.SLAVES(4), .ARBITER_TYPE(PZVBUS_ARB_ROUND_ROBIN), .MAX_BURST(4),
                        .OUTPUT_SLICE(1'b1)) u_c (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(c_en), .slave_if(c_s),
      .master_if(c_m), .o_grant(c_grant), .o_locked(c_locked));
   pzvbus_arbiter_mux #(.SLAVES(2), .ARBITER_TYPE(PZVBUS_ARB_FIXED), .MAX_BURST(1),
                        .OUTPUT_SLICE(1'b0)) u_d (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(d_en), .slave_if(d_s),
      .master_if(d_m), .o_grant(d_grant), .o_locked(d_locked));

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      i_rst_n = 1'b0;
      a_valid = '0; b_valid = '0; c_valid = '0; d_valid = '0;
      a_en = '1; b_en = '1; c_en = '1; d_en = '1;
      a_mready = 1'b1; b_mready = 1'b1; c_mready = 1'b1; d_mready = 1'b1;
      tick();
      tick();
      #1;
      check("rst_a_grant", 16'(a_grant), 16'h0);
      check("rst_a_mvalid", 16'(a_mvalid), 16'h0);
      check("rst_c_locked", 16'(c_locked), 16'h0);
      check("rst_d_mvalid", 16'(d_mvalid), 16'h0);
      tick();
      i_rst_n = 1'b1;

      // Fixed priority: slaves 1 and 3 valid, slave 3 starves
      a_valid = 4'b1010;
      for (int k = 0; k < 6; k++) begin
         #1;
         check($sformatf("fix_grant_%0d", k), 16'(a_grant), 16'h2);
         check($sformatf("fix_rdy_%0d", k), 16'(a_rdy), 16'h2);
         check($sformatf("fix_locked_%0d", k), 16'(a_locked), 16'h0);
         check($sformatf("fix_mvalid_%0d", k), 16'(a_mvalid), (k > 0) ? 16'h1 : 16'h0);
         if (k > 0) check($sformatf("fix_mdata_%0d", k), a_mdata, 16'hC1);
         tick();
      end
      a_valid = '0;

      // Round-robin, all valid, single-beat grants
      b_valid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         #1;
         check($sformatf("rr_grant_%0d", k), 16'(b_grant), 16'(1 << (k % 4)));
         check($sformatf("rr_locked_%0d", k), 16'(b_locked), 16'h0);
         if (k > 0) begin
            check($sformatf("rr_mvalid_%0d", k), 16'(b_mvalid), 16'h1);
            check($sformatf("rr_mdata_%0d", k), b_mdata, 16'hC0 + 16'((k - 1) % 4));
         end
         tick();
      end
      b_valid = '0;

      // Round-robin with 4-beat bursts: slaves 0 and 2 alternate
      c_valid = 4'b0101;
      for (int k = 0; k < 12; k++) begin
         #1;
         check($sformatf("burst_grant_%0d", k), 16'(c_grant),
               (((k / 4) % 2) == 1) ? 16'h4 : 16'h1);
         check($sformatf("burst_locked_%0d", k), 16'(c_locked), ((k % 4) != 0) ? 16'h1 : 16'h0);
         if (k > 0)
            check($sformatf("burst_mdata_%0d", k), c_mdata,
                  ((((k - 1) / 4) % 2) == 1) ? 16'hC2 : 16'hC0);
         tick();
      end
      c_valid = '0;
      tick();

      // No slice: stalled offer from slave 1 holds the grant while slave 0 waits
      d_mready = 1'b0;
      d_valid  = 2'b10;
      for (int k = 0; k < 5; k++) begin
         if (k == 1) d_valid = 2'b11;
         #1;
         check($sformatf("stall_grant_%0d", k), 16'(d_grant), 16'h2);
         check($sformatf("stall_locked_%0d", k), 16'(d_locked), (k > 0) ? 16'h1 : 16'h0);
         check($sformatf("stall_mvalid_%0d", k), 16'(d_mvalid), 16'h1);
         check($sformatf("stall_mdata_%0d", k), d_mdata, 16'hC1);
         check($sformatf("stall_rdy_%0d", k), 16'(d_rdy), 16'h0);
         tick();
      end
      d_mready = 1'b1;
      #1;
      check("stall_out1_grant", 16'(d_grant), 16'h2);
      check("stall_out1_rdy", 16'(d_rdy), 16'h2);
      check("stall_out1_mdata", d_mdata, 16'hC1);
      tick();
      d_valid = 2'b01;
      #1;
      check("stall_out0_grant", 16'(d_grant), 16'h1);
      check("stall_out0_locked", 16'(d_locked), 16'h0);
      check("stall_out0_rdy", 16'(d_rdy), 16'h1);
      check("stall_out0_mdata", d_mdata, 16'hC0);
      tick();
      d_valid = '0;
      #1;
      check("stall_idle_mvalid", 16'(d_mvalid), 16'h0);
      check("stall_idle_grant", 16'(d_grant), 16'h0);
      tick();

      // Request enable masks slave 0 until re-enabled
      d_en    = 2'b10;
      d_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("en_grant_%0d", k), 16'(d_grant), 16'h2);
         check($sformatf("en_rdy_%0d", k), 16'(d_rdy), 16'h2);
         tick();
      end
      d_en = 2'b11;
      #1;
      check("en_regrant", 16'(d_grant), 16'h1);
      check("en_regrant_rdy", 16'(d_rdy), 16'h1);
      tick();
      d_valid = '0;
      tick();

      // Reset mid-burst with the slice full; RR pointer currently at 1
      c_mready = 1'b0;
      c_valid  = 4'b0101;
      #1;
      check("rst_pre_grant_a", 16'(c_grant), 16'h4);
      tick();
      #1;
      check("rst_pre_grant_b", 16'(c_grant), 16'h4);
      check("rst_pre_locked_b", 16'(c_locked), 16'h1);
      tick();
      #1;
      check("rst_full_mvalid", 16'(c_mvalid), 16'h1);
      check("rst_full_mdata", c_mdata, 16'hC2);
      check("rst_full_rdy", 16'(c_rdy), 16'h0);
      check("rst_full_locked", 16'(c_locked), 16'h1);
      i_rst_n = 1'b0;
      #1;
      check("rst_async_mvalid", 16'(c_mvalid), 16'h0);
      check("rst_async_grant", 16'(c_grant), 16'h0);
      check("rst_async_locked", 16'(c_locked), 16'h0);
      tick();
      i_rst_n  = 1'b1;
      c_mready = 1'b1;
      #1;
      check("rst_after_grant", 16'(c_grant), 16'h1);
      check("rst_after_locked", 16'(c_locked), 16'h0);
      check("rst_after_mvalid", 16'(c_mvalid), 16'h0);
      tick();
      #1;
      check("rst_after2_grant", 16'(c_grant), 16'h1);
      check("rst_after2_locked", 16'(c_locked), 16'h1);
      check("rst_after2_mvalid", 16'(c_mvalid), 16'h1);
      check("rst_after2_mdata", c_mdata, 16'hC0);
      c_valid = '0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
